// File: rtl/gcd_reduce_n_if.sv
// ---------------------------------------------------------------------------
// gcd_reduce_n_if
// Handshake/display bundle between the button/switch conditioning, the
// gcd_reduce_n core and the seven-segment driver.
//   select    : operand shown/edited (out-of-range values address channel 0)
//   add       : raw button, rising edge adds data_in to the selected operand
//   next      : raw button, rising edge advances the state machine
//   data_in   : addend
//   data_out  : registered display value
//   state_out : current state (SETUP=0, CALC=1, SHOW=2, COUNT=3)
//   busy      : high while the core is computing
// master = board side (drives buttons), slave = gcd_reduce_n core.
// ---------------------------------------------------------------------------
interface gcd_reduce_n_if #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [SEL_W-1:0] select;
   logic             add;
   logic             next;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic [1:0]       state_out;
   logic             busy;

   modport master (
      output select, add, next, data_in,
      input  data_out, state_out, busy
   );

   modport slave (
      input  select, add, next, data_in,
      output data_out, state_out, busy
   );
endinterface

// File: rtl/gcd_reduce_n.sv
// ---------------------------------------------------------------------------
// gcd_reduce_n
// Collects CHANNELS operands entered by button pulses, computes their common
// GCD (subtraction Euclid, one step per cycle), divides every operand by it
// (restoring division, one quotient bit per cycle), shows the reduced
// operands and finally counts the GCD down on a tick of NUM clk cycles.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gcd_reduce_n_if.slave (select, add, next, data_in in;
//           data_out, state_out, busy out, all outputs registered)
//
// Configuration macro:
//   GCD_REDUCE_SAT_EN : when defined, SETUP additions saturate at BASE-1
//                       instead of wrapping modulo BASE.
// ---------------------------------------------------------------------------
module gcd_reduce_n #(
   parameter int WIDTH    = 4,
   parameter int CHANNELS = 2,
   parameter int BASE     = 10,
   parameter int NUM      = 50_000_000
) (
   input logic         clk,
   input logic         rst_n,
   gcd_reduce_n_if.slave bus
);
   localparam int IDX_W = $clog2(CHANNELS);
   localparam int BIT_W = $clog2(WIDTH + 1);
   localparam int CNT_W = (NUM > 1) ? $clog2(NUM) : 1;

   localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(CHANNELS - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(NUM - 1);
   localparam logic [WIDTH:0]   BASE_W    = (WIDTH + 1)'(BASE);
   localparam logic [WIDTH:0]   BASE_MAX  = (WIDTH + 1)'(BASE - 1);

   typedef enum logic [1:0] {
      ST_SETUP = 2'd0,
      ST_CALC  = 2'd1,
      ST_SHOW  = 2'd2,
      ST_COUNT = 2'd3
   } state_t;

   typedef enum logic {
      PH_GCD = 1'b0,
      PH_DIV = 1'b1
   } phase_t;

   // Operand update; the sum is formed one bit wider so it cannot overflow.
   function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      logic [WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
`ifdef GCD_REDUCE_SAT_EN
      return (s > BASE_MAX) ? BASE_MAX[WIDTH-1:0] : s[WIDTH-1:0];
`else
      return WIDTH'(s % BASE_W);
`endif
   endfunction

   state_t           state_q;
   phase_t           phase_q;
   logic [IDX_W-1:0] idx_q;
   logic [WIDTH-1:0] op_q  [CHANNELS];
   logic [WIDTH-1:0] res_q [CHANNELS];
   logic [WIDTH-1:0] g_q, b_q, rem_q, dq_q, count_q, data_out_q;
   logic [BIT_W-1:0] bit_q;
   logic [CNT_W-1:0] tick_q;
   logic             busy_q;
   logic             add_s_q, add_p_q, next_s_q, next_p_q;

   logic             add_pulse, next_pulse;
   logic [IDX_W-1:0] sel_idx, idx_inc;
   logic [WIDTH-1:0] op_d [CHANNELS];
   logic             gcd_done;
   logic [WIDTH-1:0] g_d, b_d, rem_d, dq_d;
   logic [WIDTH:0]   rem_sh, trial;
   logic             count_ok;

   assign add_pulse  = add_s_q & ~add_p_q;
   assign next_pulse = next_s_q & ~next_p_q;
   assign sel_idx    = (bus.select > LAST_CH) ? '0 : bus.select;
   assign idx_inc    = idx_q + 1'b1;

   // Operands as they will be after this cycle's add (used by the same-cycle
   // next so CALC starts from the updated value).
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) op_d[i] = op_q[i];
      if (state_q == ST_SETUP && add_pulse) op_d[sel_idx] = add_op(op_q[sel_idx], bus.data_in);
   end

   // One subtraction-Euclid step on (g_q, b_q); gcd(0, x) = x.
   always_comb begin
      gcd_done = 1'b0;
      g_d      = g_q;
      b_d      = b_q;
      if (g_q == '0) begin
         gcd_done = 1'b1;
         g_d      = b_q;
      end else if (b_q == '0 || g_q == b_q) begin
         gcd_done = 1'b1;
      end else if (g_q > b_q) begin
         g_d = g_q - b_q;
      end else begin
         b_d = b_q - g_q;
      end
   end

   // One restoring-division step; trial[WIDTH] set means the subtraction borrowed.
   always_comb begin
      rem_sh = {rem_q, dq_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, g_q};
      if (!trial[WIDTH]) begin
         rem_d = trial[WIDTH-1:0];
         dq_d  = (dq_q << 1) | WIDTH'(1);
      end else begin
         rem_d = rem_sh[WIDTH-1:0];
         dq_d  = dq_q << 1;
      end
   end

   // count divides every operand exactly when it divides their GCD.
   assign count_ok = (count_q != '0) ? ((g_q % count_q) == '0) : 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_SETUP;
         phase_q    <= PH_GCD;
         idx_q      <= '0;
         g_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         dq_q       <= '0;
         bit_q      <= '0;
         count_q    <= '0;
         tick_q     <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         add_s_q    <= 1'b0;
         add_p_q    <= 1'b0;
         next_s_q   <= 1'b0;
         next_p_q   <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            op_q[i]  <= '0;
            res_q[i] <= '0;
         end
      end else begin
         add_s_q  <= bus.add;
         add_p_q  <= add_s_q;
         next_s_q <= bus.next;
         next_p_q <= next_s_q;
         case (state_q)
            ST_SETUP: begin
               op_q       <= op_d;
               data_out_q <= op_d[sel_idx];
               if (next_pulse) begin
                  state_q <= ST_CALC;
                  busy_q  <= 1'b1;
                  phase_q <= PH_GCD;
                  idx_q   <= IDX_W'(1);
                  g_q     <= op_d[0];
                  b_q     <= op_d[1];
               end
            end
            ST_CALC: begin
               if (phase_q == PH_GCD) begin
                  g_q <= g_d;
                  b_q <= b_d;
                  if (gcd_done) begin
                     if (idx_q != LAST_CH) begin
                        idx_q <= idx_inc;
                        b_q   <= op_q[idx_inc];
                     end else if (g_d == '0) begin
                        // All operands zero: nothing to divide.
                        for (int i = 0; i < CHANNELS; i++) res_q[i] <= '0;
                        state_q    <= ST_SHOW;
                        busy_q     <= 1'b0;
                        data_out_q <= '0;
                     end else begin
                        phase_q <= PH_DIV;
                        idx_q   <= '0;
                        rem_q   <= '0;
                        dq_q    <= op_q[0];
                        bit_q   <= '0;
                     end
                  end
               end else begin
                  rem_q <= rem_d;
                  dq_q  <= dq_d;
                  bit_q <= bit_q + 1'b1;
                  if (bit_q == LAST_BIT) begin
                     res_q[idx_q] <= dq_d;
                     rem_q        <= '0;
                     bit_q        <= '0;
                     if (idx_q == LAST_CH) begin
                        state_q    <= ST_SHOW;
                        busy_q     <= 1'b0;
                        data_out_q <= (sel_idx == LAST_CH) ? dq_d : res_q[sel_idx];
                     end else begin
                        idx_q <= idx_inc;
                        dq_q  <= op_q[idx_inc];
                     end
                  end
               end
            end
            ST_SHOW: begin
               data_out_q <= res_q[sel_idx];
               if (next_pulse) begin
                  state_q    <= ST_COUNT;
                  count_q    <= g_q;
                  tick_q     <= '0;
                  data_out_q <= g_q;
               end
            end
            default: begin
               if (count_q == '0 || (next_pulse && count_ok)) begin
                  state_q    <= ST_SETUP;
                  data_out_q <= op_q[sel_idx];
               end else if (tick_q == TICK_LAST) begin
                  tick_q     <= '0;
                  count_q    <= count_q - 1'b1;
                  data_out_q <= count_q - 1'b1;
               end else begin
                  tick_q     <= tick_q + 1'b1;
                  data_out_q <= count_q;
               end
            end
         endcase
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.state_out = state_q;
   assign bus.busy      = busy_q;
endmodule
